mem_stage_cached: RTL
=====================

# mem_stage_cached

Parametrised memory pipeline stage with an integrated direct-mapped, write-through, no-write-allocate data cache and a line-fill state machine. It sits between the EX/MEM and MEM/WB pipeline registers. It serves loads and stores from the ALU-computed address, forwards a WB-stage load result into a dependent store, and drives a pipelined request/valid interface to main memory. It holds the pipeline via `Stall` on misses and on stores blocked by memory backpressure.

## Interface
- `DATA_W`, 16: data word width in bits.
- `ADDR_W`, 16: byte address width.
- `LINES`, 8: cache lines; power of two, at least 2.
- `WORDS`, 8: words per line; power of two, at least 2.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `MemEn`, `MemWr`  in  1 each: access enable; write (store) when 1, load when 0.
- `Opcode`, `WBOpcode`  in  4 each: opcode of the instruction in MEM and in WB.
- `SrcReg`, `WBRegWrite`  in  4 each: store data source register; WB destination register.
- `RegRead`, `WBMemOut`  in  DATA_W each: store data from the register file; WB load result.
- `Addr`  in  ADDR_W: byte address from ALU.
- `MemOut`  out  DATA_W: load data to MEM/WB.
- `Stall`  out  1: freezes PC and all upstream pipeline registers.
- `MemReq`, `MemWe`  out  1 each: memory request valid; write flag.
- `MemAddr`  out  ADDR_W: memory address.
- `MemWData`  out  DATA_W: memory write data.
- `MemBusy`  in  1: memory cannot accept a request this cycle.
- `MemRdata`, `MemRvalid`  in  DATA_W, 1: read return data and strobe; returns arrive in request order.
- `HitCount`, `MissCount`  out  16 each: performance counters (see Configuration).

## Operation
- Address split: bit 0 ignored (word aligned). `OFF=log2(WORDS)` bits from bit 1, then `IDX=log2(LINES)` bits, tag = remaining upper bits.
- Forwarding: `Fwd = (Opcode==4'b1001) & (WBOpcode==4'b1000) & (WBRegWrite==SrcReg) & (WBRegWrite!=0)`.
  - Store data `SD = Fwd ? WBMemOut : RegRead`.
  - `MemWData = SD` at all times.
- Hit = `valid[idx] & tag[idx]==addr tag`.
- States: IDLE, FILL, DONE.
- IDLE, load, hit: `MemOut` = cached word, combinationally in the same cycle. `Stall=0`.
- IDLE, load, miss:
  - `Stall=1`.
  - Latch line base (offset zeroed) and index.
  - Go to FILL.
- FILL:
  - Issue a read request (`MemReq=1`, `MemWe=0`) at `base + 2*issueCnt` in every cycle where `issueCnt<WORDS` and `!MemBusy`.
  - Each `MemRvalid` writes `MemRdata` into word `retCnt`, then increments `retCnt`.
  - When `retCnt` reaches `WORDS`: set `valid[idx]`, write tag, go to DONE.
  - `Stall=1` throughout.
- DONE: one cycle, `Stall=1`, then IDLE. The replayed load then hits.
- IDLE, store:
  - `MemReq=1`, `MemWe=1`, `MemAddr=Addr`.
  - `Stall = MemBusy`.
  - On the accept cycle (`!MemBusy`), a hit also writes `SD` into the cached word. A miss does not allocate.
- `MemEn=0`: no request, `Stall=0`, `MemOut=0`.
- `MemRvalid` in IDLE or DONE is ignored; stale returns after reset are dropped.
- Counters increment once per completed access: a hit on a serviced load/store, or a load miss entering FILL. Both counters saturate at 16'hFFFF.

## Timing
- Reset (asynchronous, `rst=0`):
  - state IDLE.
  - all valid bits 0.
  - `issueCnt=retCnt=0`.
  - counters 0.
  - `Stall=0`, `MemReq=0`, `MemOut=0`.
- Load hit latency: 0 cycles (combinational).
- Miss penalty: at least `WORDS` + memory latency + 1 (DONE) cycles.
- `MemReq` is never asserted in DONE.
- A request is consumed only when `MemReq & !MemBusy`.
- Reset asserted mid-FILL aborts the fill. The line stays invalid and `Stall` drops asynchronously.
- Forwarding is evaluated combinationally in the cycle the store is accepted.

## Configuration
- `MEM_STAGE_PERF_EN`, defined: `HitCount`/`MissCount` registers are implemented as described.
- Not defined: no counter flops are instantiated, and both outputs are tied to 16'h0000.
- Cache behaviour is identical either way.

## Test plan
- Cold load, `Addr=16'h0024`, `WORDS=8`, memory latency 4:
  - `Stall` high.
  - 8 reads at 16'h0020..16'h002E.
  - DONE, then `MemOut` = word at 16'h0024.
  - Second load of 16'h0026 hits with `Stall=0`.
- Store of 16'hBEEF to cached 16'h0022 with `MemBusy=1` for 3 cycles:
  - `Stall` high for 3 cycles.
  - One write on cycle 4.
  - A subsequent load of 16'h0022 returns 16'hBEEF with no refill.
- Store miss to 16'h0100: one memory write, no fill; a later load of 16'h0100 misses.
- Forwarding: WB is a load (opcode 8) writing R3 with 16'h1234; MEM is a store (opcode 9) with `SrcReg=3`, `RegRead=16'h0000`.
  - `MemWData=16'h1234`.
  - With `WBRegWrite=SrcReg=0`, `MemWData=RegRead`.
- Drive `rst=0` after 3 fill returns, then release:
  - state IDLE, `Stall=0`.
  - Stray `MemRvalid` is ignored.
  - Reload of the same address misses again.
  - With `MEM_STAGE_PERF_EN`: after 5 hits and 2 misses, `HitCount=5` and `MissCount=2`.

Source files
------------

// File: rtl/mem_stage_cached.sv
// MEM stage with a direct-mapped write-through, no-write-allocate data cache.
// Define MEM_STAGE_PERF_EN to build the HitCount/MissCount counters.
module mem_stage_cached #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int LINES  = 8,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemEn,
    input  logic              MemWr,
    input  logic [3:0]        Opcode,
    input  logic [3:0]        WBOpcode,
    input  logic [3:0]        SrcReg,
    input  logic [3:0]        WBRegWrite,
    input  logic [DATA_W-1:0] RegRead,
    input  logic [DATA_W-1:0] WBMemOut,
    input  logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] MemOut,
    output logic              Stall,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic              MemBusy,
    input  logic [DATA_W-1:0] MemRdata,
    input  logic              MemRvalid,
    output logic [15:0]       HitCount,
    output logic [15:0]       MissCount
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;
    localparam int CNT_W = OFF_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } stateT;

    stateT state;

    logic [DATA_W-1:0] dataArr [LINES*WORDS];
    logic [TAG_W-1:0]  tagArr  [LINES];
    logic [LINES-1:0]  validArr;

    logic [IDX_W-1:0] fillIdx;
    logic [TAG_W-1:0] fillTag;
    logic [CNT_W-1:0] issueCnt;
    logic [CNT_W-1:0] retCnt;

    logic [OFF_W-1:0] addrOff;
    logic [IDX_W-1:0] addrIdx;
    logic [TAG_W-1:0] addrTag;
    logic             unusedBits;

    assign addrOff    = Addr[OFF_W:1];
    assign addrIdx    = Addr[OFF_W+IDX_W:OFF_W+1];
    assign addrTag    = Addr[ADDR_W-1:ADDR_W-TAG_W];
    assign unusedBits = Addr[0];

    logic              hit;
    logic [DATA_W-1:0] cachedWord;
    logic              fwd;
    logic [DATA_W-1:0] storeData;
    logic              isLoad;
    logic              isStore;
    logic              idle;
    logic              loadMiss;
    logic              storeAcc;
    logic              issueOk;
    logic              lastRet;
    logic [ADDR_W-1:0] fillAddr;

    assign hit        = validArr[addrIdx] && (tagArr[addrIdx] == addrTag);
    assign cachedWord = dataArr[{addrIdx, addrOff}];

    // A store reading the register a WB-stage load is about to write.
    assign fwd = (Opcode == 4'b1001) && (WBOpcode == 4'b1000) &&
                 (WBRegWrite == SrcReg) && (WBRegWrite != 4'd0);
    assign storeData = fwd ? WBMemOut : RegRead;
    assign MemWData  = storeData;

    assign isLoad   = MemEn & ~MemWr;
    assign isStore  = MemEn & MemWr;
    assign idle     = (state == IDLE);
    assign loadMiss = idle & isLoad & ~hit;
    assign storeAcc = idle & isStore & ~MemBusy;
    assign issueOk  = (state == FILL) && (issueCnt < CNT_W'(WORDS)) && !MemBusy;
    assign lastRet  = (state == FILL) && MemRvalid && (retCnt == CNT_W'(WORDS - 1));
    assign fillAddr = {fillTag, fillIdx, issueCnt[OFF_W-1:0], 1'b0};

    assign MemOut = (isLoad && hit) ? cachedWord : '0;

    // Gated by rst so that Stall and MemReq drop the moment reset asserts.
    always_comb begin
        MemReq  = 1'b0;
        MemWe   = 1'b0;
        Stall   = 1'b0;
        MemAddr = Addr;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    MemReq = isStore;
                    MemWe  = isStore;
                    Stall  = loadMiss | (isStore & MemBusy);
                end
                FILL: begin
                    MemReq  = issueOk;
                    MemAddr = fillAddr;
                    Stall   = 1'b1;
                end
                DONE: begin
                    Stall = 1'b1;
                end
                default: begin
                    Stall = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            validArr <= '0;
            issueCnt <= '0;
            retCnt   <= '0;
            fillIdx  <= '0;
            fillTag  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (loadMiss) begin
                        state             <= FILL;
                        fillIdx           <= addrIdx;
                        fillTag           <= addrTag;
                        validArr[addrIdx] <= 1'b0;
                        issueCnt          <= '0;
                        retCnt            <= '0;
                    end
                end
                FILL: begin
                    if (issueOk) begin
                        issueCnt <= issueCnt + 1'b1;
                    end
                    if (MemRvalid) begin
                        retCnt <= retCnt + 1'b1;
                    end
                    if (lastRet) begin
                        validArr[fillIdx] <= 1'b1;
                        state             <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line data and tags need no reset; validArr alone qualifies them.
    always_ff @(posedge clk) begin
        if ((state == FILL) && MemRvalid) begin
            dataArr[{fillIdx, retCnt[OFF_W-1:0]}] <= MemRdata;
        end else if (storeAcc && hit) begin
            dataArr[{addrIdx, addrOff}] <= storeData;
        end
        if (lastRet) begin
            tagArr[fillIdx] <= fillTag;
        end
    end

`ifdef MEM_STAGE_PERF_EN
    logic [15:0] hitCnt;
    logic [15:0] missCnt;
    logic        hitEv;

    assign hitEv = idle & MemEn & hit & (~MemWr | ~MemBusy);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hitCnt  <= '0;
            missCnt <= '0;
        end else begin
            if (hitEv && (hitCnt != 16'hFFFF)) begin
                hitCnt <= hitCnt + 16'd1;
            end
            if (loadMiss && (missCnt != 16'hFFFF)) begin
                missCnt <= missCnt + 16'd1;
            end
        end
    end

    assign HitCount  = hitCnt;
    assign MissCount = missCnt;
`else
    assign HitCount  = 16'h0000;
    assign MissCount = 16'h0000;
`endif

endmodule
